// File: rtl/nec_ir_pkg.sv
// Shared types and timing windows for the NEC IR frame decoder.
// All widths are in sample-strobe units (1/8 of an NEC unit).
package nec_ir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStop,
        StRptStop
    } nec_state_e;

    localparam logic [7:0] LeadMarkMin  = 8'd112;
    localparam logic [7:0] LeadMarkMax  = 8'd144;
    localparam logic [7:0] LeadSpaceMin = 8'd56;
    localparam logic [7:0] LeadSpaceMax = 8'd72;
    localparam logic [7:0] RptSpaceMin  = 8'd24;
    localparam logic [7:0] RptSpaceMax  = 8'd40;
    localparam logic [7:0] BitMarkMin   = 8'd4;
    localparam logic [7:0] BitMarkMax   = 8'd12;
    localparam logic [7:0] Space0Min    = 8'd4;
    localparam logic [7:0] Space0Max    = 8'd12;
    localparam logic [7:0] Space1Min    = 8'd16;
    localparam logic [7:0] Space1Max    = 8'd32;
    localparam logic [7:0] Timeout      = 8'd160;

    // Byte positions in the LSB-first shift register.
    localparam int unsigned AddrLsb    = 0;
    localparam int unsigned AddrInvLsb = 8;
    localparam int unsigned CmdLsb     = 16;
    localparam int unsigned CmdInvLsb  = 24;

    function automatic logic in_window(input logic [7:0] w, input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/nec_ir_input_filter.sv
// Synchroniser, sample prescaler and 3-sample majority filter for the raw IR pin.
// Emits one-cycle mark edge strobes, delayed one cycle after the sample strobe that saw them.
module nec_ir_input_filter #(
    parameter int unsigned SAMPLE_DIV    = 2813,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic ir_i,
    output logic sample_stb_o,
    output logic mark_rise_o,
    output logic mark_fall_o
);

    // Raw pin level when no carrier is present; reset to it so reset never looks like an edge.
    localparam logic        IdleLevel = IR_ACTIVE_LOW;
    localparam logic [15:0] PrescLast = 16'(SAMPLE_DIV - 1);

    logic [1:0]  sync_q;
    logic [15:0] presc_q, presc_d;
    logic [2:0]  hist_q, hist_d;
    logic        mark_q, mark_d;
    logic        rise_q, rise_d;
    logic        fall_q, fall_d;

    assign sample_stb_o = (presc_q == PrescLast);
    assign mark_rise_o  = rise_q;
    assign mark_fall_o  = fall_q;

    always_comb begin
        presc_d = sample_stb_o ? 16'd0 : presc_q + 16'd1;
        hist_d  = hist_q;
        mark_d  = mark_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_stb_o) begin
            hist_d = {hist_q[1:0], sync_q[1]};
            mark_d = ((hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) | (hist_d[1] & hist_d[2]))
                     ^ IR_ACTIVE_LOW;
            rise_d = mark_d & ~mark_q;
            fall_d = ~mark_d & mark_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q  <= {2{IdleLevel}};
            presc_q <= 16'd0;
            hist_q  <= {3{IdleLevel}};
            mark_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ir_i};
            presc_q <= presc_d;
            hist_q  <= hist_d;
            mark_q  <= mark_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

endmodule

// File: rtl/nec_ir_frame_decoder.sv
// NEC IR frame decoder: width measurement, protocol FSM, inverse-byte check and output strobes.
// Consumes filtered mark edges from nec_ir_input_filter.
module nec_ir_frame_decoder
    import nec_ir_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = 2813,
    parameter bit          IR_ACTIVE_LOW = 1'b1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       enable_i,
    input  logic       ir_i,
    output logic       frame_valid_o,
    output logic       repeat_o,
    output logic       error_o,
    output logic [7:0] addr_o,
    output logic [7:0] data_o,
    output logic       busy_o
);

    logic sample_stb, mark_rise, mark_fall, mark_edge;

    nec_ir_input_filter #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
    ) u_filter (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .ir_i         (ir_i),
        .sample_stb_o (sample_stb),
        .mark_rise_o  (mark_rise),
        .mark_fall_o  (mark_fall)
    );

    assign mark_edge = mark_rise | mark_fall;

    nec_state_e  state_q, state_d;
    logic [7:0]  width_q, width_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] sr_q, sr_d;
    logic [7:0]  addr_q, addr_d, data_q, data_d;
    logic        last_valid_q, last_valid_d;
    logic        frame_valid_q, frame_valid_d;
    logic        repeat_q, repeat_d;
    logic        error_q, error_d;
    logic        sp0_hit, sp1_hit, inv_ok;

    assign sp0_hit = in_window(width_q, Space0Min, Space0Max);
    assign sp1_hit = in_window(width_q, Space1Min, Space1Max);
    assign inv_ok  = ((sr_q[AddrLsb +: 8] ^ sr_q[AddrInvLsb +: 8]) == 8'hFF)
                  && ((sr_q[CmdLsb +: 8] ^ sr_q[CmdInvLsb +: 8]) == 8'hFF);

    // Width is the sample count since the previous edge, so it is read before being cleared.
    always_comb begin
        width_d = width_q;
        if (mark_edge) begin
            width_d = 8'd0;
        end else if (sample_stb && width_q != 8'hFF) begin
            width_d = width_q + 8'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        last_valid_d  = last_valid_q;
        frame_valid_d = 1'b0;
        repeat_d      = 1'b0;
        error_d       = 1'b0;
        if (!enable_i) begin
            state_d   = StIdle;
            bit_cnt_d = 5'd0;
            sr_d      = 32'd0;
        end else begin
            unique case (state_q)
                StIdle: if (mark_rise) state_d = StLeadMark;
                StLeadMark: if (mark_fall) begin
                    if (in_window(width_q, LeadMarkMin, LeadMarkMax)) begin
                        state_d = StLeadSpace;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                StLeadSpace: if (mark_rise) begin
                    if (in_window(width_q, LeadSpaceMin, LeadSpaceMax)) begin
                        bit_cnt_d = 5'd0;
                        sr_d      = 32'd0;
                        state_d   = StBitMark;
                    end else if (in_window(width_q, RptSpaceMin, RptSpaceMax)) begin
                        state_d = StRptStop;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBitMark: if (mark_fall) begin
                    if (in_window(width_q, BitMarkMin, BitMarkMax)) begin
                        state_d = StBitSpace;
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBitSpace: if (mark_rise) begin
                    if (sp0_hit || sp1_hit) begin
                        sr_d = {sp1_hit, sr_q[31:1]};
                        if (bit_cnt_q == 5'd31) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            state_d   = StBitMark;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                StStop: if (mark_fall) begin
                    state_d = StIdle;
                    if (in_window(width_q, BitMarkMin, BitMarkMax) && inv_ok) begin
                        addr_d        = sr_q[AddrLsb +: 8];
                        data_d        = sr_q[CmdLsb +: 8];
                        frame_valid_d = 1'b1;
                        last_valid_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        if (in_window(width_q, BitMarkMin, BitMarkMax)) last_valid_d = 1'b0;
                    end
                end
                StRptStop: if (mark_fall) begin
                    state_d = StIdle;
                    if (in_window(width_q, BitMarkMin, BitMarkMax) && last_valid_q) begin
                        repeat_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            // An edge in the same cycle is classified instead of timing out.
            if (!mark_edge && width_q == Timeout && state_q != StIdle) begin
                error_d = 1'b1;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= StIdle;
            width_q       <= 8'd0;
            bit_cnt_q     <= 5'd0;
            sr_q          <= 32'd0;
            addr_q        <= 8'd0;
            data_q        <= 8'd0;
            last_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            repeat_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            last_valid_q  <= last_valid_d;
            frame_valid_q <= frame_valid_d;
            repeat_q      <= repeat_d;
            error_q       <= error_d;
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign repeat_o      = repeat_q;
    assign error_o       = error_q;
    assign addr_o        = addr_q;
    assign data_o        = data_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_nec_ir_frame_decoder.sv
// Scoreboard bench for nec_ir_frame_decoder: drives scaled NEC waveforms on ir_i
// (one NEC unit = 8 samples) and compares observed strobes against expected events.
module tb_nec_ir_frame_decoder;

    localparam int unsigned SampleDiv = 8;
    localparam int unsigned UnitCyc   = SampleDiv * 8;
    localparam logic [1:0]  KFrame = 2'd1, KRpt = 2'd2, KErr = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, ir = 1'b1;
    logic       frame_valid, rpt, err, busy;
    logic [7:0] addr, data;

    int   checks = 0, errors = 0, multi_hot = 0;
    ev_t  exp_q[$], obs_q[$];
    ev_t  e, o;
    logic [7:0] m_addr = 8'h00, m_data = 8'h00;
    logic       m_last = 1'b0;

    nec_ir_frame_decoder #(
        .SAMPLE_DIV    (SampleDiv),
        .IR_ACTIVE_LOW (1'b1)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .enable_i      (en),
        .ir_i          (ir),
        .frame_valid_o (frame_valid),
        .repeat_o      (rpt),
        .error_o       (err),
        .addr_o        (addr),
        .data_o        (data),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) obs_q.push_back({KFrame, addr, data});
            if (rpt)         obs_q.push_back({KRpt, addr, data});
            if (err)         obs_q.push_back({KErr, addr, data});
            if ((32'(frame_valid) + 32'(rpt) + 32'(err)) > 1) multi_hot++;
        end
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic hold(input logic lvl, input int units);
        ir = lvl;
        repeat (units * UnitCyc) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, 1);
            hold(1'b1, w[i] ? 3 : 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci);
        hold(1'b0, 16);
        hold(1'b1, 8);
        send_bits({ci, c, ~a, a}, 32);
        hold(1'b0, 1);
        ir = 1'b1;
        if ((c ^ ci) == 8'hFF) begin
            m_addr = a;
            m_data = c;
            m_last = 1'b1;
            exp_q.push_back({KFrame, a, c});
        end else begin
            m_last = 1'b0;
            exp_q.push_back({KErr, m_addr, m_data});
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, 16);
        hold(1'b1, 4);
        hold(1'b0, 1);
        ir = 1'b1;
        exp_q.push_back({m_last ? KRpt : KErr, m_addr, m_data});
    endtask

    task automatic settle(input int samples);
        repeat (samples * SampleDiv) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({frame_valid, rpt, err, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0000", {frame_valid, rpt, err, busy});
        end
        rst = 1'b0;
        settle(10);
        checks++;
        if ({addr, data} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: got %h required 0000", {addr, data});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_repeat_after_reset();
        send_repeat();
        settle(40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rpt_after_reset count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rpt_after_reset event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 8'h3C, 8'hC3);
        settle(40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_frame count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_frame event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_repeat();
        send_frame(8'h12, 8'h34, 8'hCB);
        settle(40);
        send_repeat();
        settle(40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL repeat count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL repeat event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_bad_inverse();
        send_frame(8'hA5, 8'h3C, 8'hC4);
        settle(40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bad_inverse count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bad_inverse event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_timeout();
        hold(1'b0, 16);
        ir = 1'b1;
        exp_q.push_back({KErr, m_addr, m_data});
        settle(10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_high: got %b required 1", busy);
        end
        settle(200);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy_low: got %b required 0", busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        hold(1'b0, 16);
        hold(1'b1, 8);
        send_bits(32'h3CC35AA5, 17);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_addr = 8'h00;
        m_data = 8'h00;
        m_last = 1'b0;
        exp_q.delete();
        obs_q.delete();
        checks++;
        if ({busy, addr, data} !== 17'h0) begin
            errors++;
            $display("FAIL mid_reset_state: got %h required 00000", {busy, addr, data});
        end
        repeat (5) begin
            ir = 1'b0;
            repeat (2) @(negedge clk);
            ir = 1'b1;
            repeat (40) @(negedge clk);
        end
        settle(20);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ignored: got %0d events busy %b required 0 events busy 0",
                     obs_q.size(), busy);
        end
        send_frame(8'h00, 8'hFF, 8'h00);
        settle(40);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL post_reset_frame count: got %0d required %0d", obs_q.size(),
                     exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_frame event: got %h required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (multi_hot != 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d multi-hot cycles required 0", multi_hot);
        end
    endtask

    initial begin
        test_reset();
        test_repeat_after_reset();
        test_single_frame();
        test_repeat();
        test_bad_inverse();
        test_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
